// File: rtl/counter_session_arbiter.sv
// ---------------------------------------------------------------------------
// counter_session_arbiter
//
// Shares one WIDTH-bit up-counter between NUM_REQ requesters. Each requester
// asks for a counting session by holding req[i] high; the winner, picked
// round robin while idle, gets its start value loaded into the counter. The
// counter then increments to all ones (unless frozen by hold), after which the
// owner receives a one-cycle done pulse and the block returns to idle.
// Dropping req of the owner during a run aborts the session silently.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   req        per-requester session request (level, held for the session)
//   start_val  packed start values, requester i at [i*WIDTH +: WIDTH]
//   hold       freezes the count while running
//   grant      one-hot owner of the counter, zero when idle
//   busy       high while running or signalling completion
//   count      counter value
//   done       one-cycle completion pulse to the owner
// ---------------------------------------------------------------------------
module counter_session_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] start_val,
  input  logic                     hold,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [WIDTH-1:0]         count,
  output logic [NUM_REQ-1:0]       done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic               busy_reg, busy_next;
  logic [WIDTH-1:0]   count_reg, count_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;

  // Unpacked view of the start values so the winner can index them directly.
  logic [WIDTH-1:0] start_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_start
      assign start_arr[gi] = start_val[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin search: first asserted request at or after the pointer,
  // wrapping past the top index back to zero.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_reg) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  // Pointer value after the owner's session ends, wrapping modulo NUM_REQ.
  logic [IDX_W-1:0] owner_inc;
  assign owner_inc = (int'(owner_reg) == NUM_REQ - 1) ? '0 : owner_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    done_next  = '0;
    busy_next  = busy_reg;
    count_next = count_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;

    unique case (state_reg)
      ST_IDLE: begin
        grant_next = '0;
        busy_next  = 1'b0;
        if (win_found) begin
          grant_next[win_idx] = 1'b1;
          count_next          = start_arr[win_idx];
          busy_next           = 1'b1;
          owner_next          = win_idx;
          state_next          = ST_RUN;
        end
      end

      ST_RUN: begin
        // Abort outranks both hold and completion.
        if (!req[owner_reg]) begin
          state_next = ST_IDLE;
          grant_next = '0;
          busy_next  = 1'b0;
          ptr_next   = owner_inc;
        end else if (!hold) begin
          if (count_reg == CNT_MAX) begin
            state_next           = ST_DONE;
            done_next[owner_reg] = 1'b1;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
        grant_next = '0;
        busy_next  = 1'b0;
        ptr_next   = owner_inc;
      end

      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      done_reg  <= '0;
      busy_reg  <= 1'b0;
      count_reg <= '0;
      ptr_reg   <= '0;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
      count_reg <= count_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
    end
  end

  assign grant = grant_reg;
  assign done  = done_reg;
  assign busy  = busy_reg;
  assign count = count_reg;

endmodule

// File: tb/tb_counter_session_arbiter.sv
// ---------------------------------------------------------------------------
// tb_counter_session_arbiter
//
// Directed bench for counter_session_arbiter (NUM_REQ=4, WIDTH=4). Inputs are
// driven on the falling edge, outputs sampled on the following falling edge.
// ---------------------------------------------------------------------------
module tb_counter_session_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;

  logic                     clk;
  logic                     reset_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] start_val;
  logic                     hold;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [WIDTH-1:0]         count;
  logic [NUM_REQ-1:0]       done;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  counter_session_arbiter #(
    .NUM_REQ(NUM_REQ),
    .WIDTH  (WIDTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .start_val(start_val),
    .hold     (hold),
    .grant    (grant),
    .busy     (busy),
    .count    (count),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic b,
                         input logic [3:0] c, input logic [3:0] d);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".done"},  32'(done),  32'(d));
  endtask

  // One round-robin session with start value E: RUN E, RUN F, DONE, IDLE.
  task automatic rr_session(input string tag, input logic [3:0] g);
    tick(); chk_all({tag, ".load"}, g, 1'b1, 4'hE, 4'h0);
    tick(); chk_all({tag, ".run"},  g, 1'b1, 4'hF, 4'h0);
    tick(); chk_all({tag, ".done"}, g, 1'b1, 4'hF, g);
    tick(); chk_all({tag, ".idle"}, 4'h0, 1'b0, 4'hF, 4'h0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req       = '0;
    start_val = '0;
    hold      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 4'h0, 1'b0, 4'h0, 4'h0);
    reset_n = 1'b1;
    tick();
    chk_all("idle0", 4'h0, 1'b0, 4'h0, 4'h0);

    // Single request from requester 1, start C.
    req = 4'b0010; start_val = 16'h00C0;
    tick(); chk_all("single.C", 4'b0010, 1'b1, 4'hC, 4'h0);
    tick(); chk_all("single.D", 4'b0010, 1'b1, 4'hD, 4'h0);
    tick(); chk_all("single.E", 4'b0010, 1'b1, 4'hE, 4'h0);
    tick(); chk_all("single.F", 4'b0010, 1'b1, 4'hF, 4'h0);
    tick(); chk_all("single.done", 4'b0010, 1'b1, 4'hF, 4'b0010);
    req = 4'b0000;
    tick(); chk_all("single.idle", 4'h0, 1'b0, 4'hF, 4'h0);

    // Round robin from a fresh pointer: order 0,1,3,0.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b1011; start_val = 16'hEEEE;
    rr_session("rr0", 4'b0001);
    rr_session("rr1", 4'b0010);
    rr_session("rr3", 4'b1000);
    rr_session("rr0b", 4'b0001);
    req = 4'b0000;

    // Hold for three cycles at E; pointer is 1, only requester 2 asks.
    req = 4'b0100; start_val = 16'h0D00;
    tick(); chk_all("hold.D", 4'b0100, 1'b1, 4'hD, 4'h0);
    tick(); chk_all("hold.E", 4'b0100, 1'b1, 4'hE, 4'h0);
    hold = 1'b1;
    tick(); chk_all("hold.h1", 4'b0100, 1'b1, 4'hE, 4'h0);
    tick(); chk_all("hold.h2", 4'b0100, 1'b1, 4'hE, 4'h0);
    tick(); chk_all("hold.h3", 4'b0100, 1'b1, 4'hE, 4'h0);
    hold = 1'b0;
    tick(); chk_all("hold.F", 4'b0100, 1'b1, 4'hF, 4'h0);
    tick(); chk_all("hold.done", 4'b0100, 1'b1, 4'hF, 4'b0100);
    req = 4'b0000;
    tick(); chk_all("hold.idle", 4'h0, 1'b0, 4'hF, 4'h0);

    // Abort requester 0 at count 5 while hold is also high.
    req = 4'b0001; start_val = 16'h00F0;
    tick(); chk_all("abort.load", 4'b0001, 1'b1, 4'h0, 4'h0);
    for (int i = 1; i <= 5; i++) tick();
    chk_all("abort.c5", 4'b0001, 1'b1, 4'h5, 4'h0);
    req = 4'b0000; hold = 1'b1;
    tick(); chk_all("abort.idle", 4'h0, 1'b0, 4'h5, 4'h0);
    hold = 1'b0;
    // Both 0 and 1 request now; the pointer moved past 0, so 1 wins.
    req = 4'b0011;
    tick(); chk_all("abort.next", 4'b0010, 1'b1, 4'hF, 4'h0);
    tick(); chk_all("abort.done", 4'b0010, 1'b1, 4'hF, 4'b0010);
    req = 4'b0000;
    tick(); chk_all("abort.idle2", 4'h0, 1'b0, 4'hF, 4'h0);

    // Start 0 on requester 2: sixteen RUN cycles, 0..F, then done.
    req = 4'b0100; start_val = 16'h0000;
    tick(); chk_all("long.load", 4'b0100, 1'b1, 4'h0, 4'h0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("long.count", 32'(count), 32'(i));
      chk("long.nodone", 32'(done), 32'h0);
    end
    tick(); chk_all("long.done", 4'b0100, 1'b1, 4'hF, 4'b0100);
    req = 4'b0000;
    tick(); chk_all("long.idle", 4'h0, 1'b0, 4'hF, 4'h0);

    // Asynchronous reset mid-run at count 7 on requester 3.
    req = 4'b1000; start_val = 16'h0000;
    tick(); chk_all("areset.load", 4'b1000, 1'b1, 4'h0, 4'h0);
    for (int i = 1; i <= 7; i++) tick();
    chk_all("areset.c7", 4'b1000, 1'b1, 4'h7, 4'h0);
    #2 reset_n = 1'b0;
    #1 chk_all("areset.async", 4'h0, 1'b0, 4'h0, 4'h0);
    start_val = 16'hF000;
    @(negedge clk);
    reset_n = 1'b1;
    tick(); chk_all("areset.regrant", 4'b1000, 1'b1, 4'hF, 4'h0);
    tick(); chk_all("areset.done", 4'b1000, 1'b1, 4'hF, 4'b1000);
    req = 4'b0000;
    tick(); chk_all("areset.idle", 4'h0, 1'b0, 4'hF, 4'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
